// File: rtl/sfp_div_arbiter.sv
// sfp_div_arbiter
//   Round-robin arbiter/sequencer sharing one sfp_custom_div divider among
//   NREQ requesters. One operation is outstanding at a time.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     req_valid/req_ready  per-requester request handshake (ready is one-hot)
//     req_a/req_b          packed operands, requester i at [i*W +: W]
//     rsp_valid            one-cycle one-hot response strobe to the owner
//     rsp_val/rsp_dz/rsp_to quotient, divide-by-zero and timeout flags
//     div_start/div_a/div_b divider command (registered)
//     div_done/div_valid/div_val divider result
module sfp_div_arbiter #(
    parameter int NREQ    = 2,
    parameter int W       = 20,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_val,
    output logic              rsp_dz,
    output logic              rsp_to,
    output logic              div_start,
    output logic [W-1:0]      div_a,
    output logic [W-1:0]      div_b,
    input  logic              div_done,
    input  logic              div_valid,
    input  logic [W-1:0]      div_val
);

    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] owner;
    logic [GW-1:0] grant;
    logic          grant_hit;
    logic [7:0]    tmo_cnt;
    int unsigned   idx;

    // Search upward from last_grant+1, wrapping modulo NREQ; the first
    // pending requester found wins.
    always_comb begin
        grant     = '0;
        grant_hit = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(last_grant) + i + 1) % NREQ;
            if (!grant_hit && req_valid[idx]) begin
                grant     = GW'(idx);
                grant_hit = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_hit)
            req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NREQ - 1);
            owner      <= '0;
            tmo_cnt    <= '0;
            rsp_valid  <= '0;
            rsp_val    <= '0;
            rsp_dz     <= 1'b0;
            rsp_to     <= 1'b0;
            div_start  <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
        end else begin
            // Strobes are raised on the transition into the state that
            // presents them, so they are high for exactly that state.
            div_start <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_hit) begin
                        div_a     <= req_a[int'(grant)*W +: W];
                        div_b     <= req_b[int'(grant)*W +: W];
                        owner     <= grant;
                        div_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (div_done) begin
                        rsp_val          <= div_valid ? div_val : '1;
                        rsp_dz           <= ~div_valid;
                        rsp_to           <= 1'b0;
                        rsp_valid[owner] <= 1'b1;
                        state            <= RESP;
                    end else if (tmo_cnt == 8'(TIMEOUT)) begin
                        rsp_val          <= '1;
                        rsp_dz           <= 1'b0;
                        rsp_to           <= 1'b1;
                        rsp_valid[owner] <= 1'b1;
                        state            <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP: begin
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfp_div_arbiter.sv
// tb_sfp_div_arbiter
//   Self-checking bench for sfp_div_arbiter with a behavioural divider stub
//   (10 busy cycles, one-cycle answer for b == 0, optional hang).
module tb_sfp_div_arbiter;

    localparam int NREQ    = 2;
    localparam int W       = 20;
    localparam int TIMEOUT = 31;
    localparam logic [W-1:0] SAT = '1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_val;
    logic              rsp_dz;
    logic              rsp_to;
    logic              div_start;
    logic [W-1:0]      div_a;
    logic [W-1:0]      div_b;
    logic              div_done;
    logic              div_valid;
    logic [W-1:0]      div_val;

    always #5 clk = ~clk;

    sfp_div_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_val(rsp_val),
        .rsp_dz(rsp_dz), .rsp_to(rsp_to),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_valid(div_valid), .div_val(div_val)
    );

    // Divider stub
    logic       stub_done;
    logic       stub_busy;
    logic       spur_done;
    logic       hang;
    int         stub_cnt;
    logic [W-1:0] stub_q;

    always @(posedge clk) begin
        if (rst) begin
            stub_busy <= 1'b0;
            stub_done <= 1'b0;
            stub_cnt  <= 0;
            div_valid <= 1'b0;
            div_val   <= '0;
        end else begin
            stub_done <= 1'b0;
            if (div_start) begin
                if (div_b == '0) begin
                    stub_done <= ~hang;
                    div_valid <= 1'b0;
                    div_val   <= '0;
                end else begin
                    stub_busy <= 1'b1;
                    stub_cnt  <= 0;
                    stub_q    <= div_a / div_b;
                end
            end else if (stub_busy) begin
                if (stub_cnt == 9) begin
                    stub_busy <= 1'b0;
                    stub_done <= ~hang;
                    div_valid <= 1'b1;
                    div_val   <= stub_q;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end
        end
    end

    assign div_done = stub_done | spur_done;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called in the phase just after a posedge; leaves the same phase.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int acc_wait, output int start_lat, output int rsp_lat,
                          output logic [NREQ-1:0] rv, output logic [W-1:0] val,
                          output logic dz, output logic to);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_valid[r]    = 1'b1;
        acc_wait = -1; start_lat = -1; rsp_lat = -1;
        rv = '0; val = '0; dz = 1'b0; to = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (acc_wait < 0) begin
                if (req_ready[r]) acc_wait = t;
            end else begin
                if (div_start && start_lat < 0) start_lat = t - acc_wait;
                if (rsp_valid != '0) begin
                    rsp_lat = t - acc_wait;
                    rv = rsp_valid; val = rsp_val; dz = rsp_dz; to = rsp_to;
                end
            end
            @(posedge clk);
            #1;
            if (acc_wait == t) req_valid[r] = 1'b0;
            if (rsp_lat >= 0) break;
        end
        req_valid[r] = 1'b0;
    endtask

    typedef struct {
        int           r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           hang;
        logic [W-1:0] ev;
        bit           edz;
        bit           eto;
        int           elat;
    } vec_t;

    task automatic new_op(input int i);
        logic [W-1:0] a, b;
        int sel;
        a   = W'($urandom);
        sel = $urandom_range(3, 0);
        if (sel == 0)      b = '0;
        else if (sel == 1) b = W'($urandom_range(15, 1));
        else               b = W'($urandom);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    // Transaction-level reference: the arbiter is free from next_free on;
    // an accept at cycle t yields a response at t+13 (t+3 for b == 0).
    task automatic random_phase(input int ncyc);
        int next_free, lastg, due, acc_t, eowner, g;
        bit found;
        logic [W-1:0] ev, a, b;
        logic edz;
        logic [NREQ-1:0] exp_ready, exp_rsp, acc;
        next_free = 0; lastg = NREQ - 1; due = -1; acc_t = -10; eowner = 0;
        ev = '0; edz = 1'b0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            exp_ready = '0;
            if (t >= next_free && req_valid != '0) begin
                found = 1'b0; g = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && req_valid[(lastg + k) % NREQ]) begin
                        g = (lastg + k) % NREQ;
                        found = 1'b1;
                    end
                end
                exp_ready[g] = 1'b1;
                a = req_a[g*W +: W];
                b = req_b[g*W +: W];
                if (b == '0) begin due = t + 3;  ev = SAT;   edz = 1'b1; end
                else         begin due = t + 13; ev = a / b; edz = 1'b0; end
                next_free = due + 1;
                eowner = g; lastg = g; acc_t = t;
            end
            check("rnd_ready", req_ready, exp_ready);
            check("rnd_start", div_start, (t == acc_t + 1));
            exp_rsp = '0;
            if (t == due) exp_rsp[eowner] = 1'b1;
            check("rnd_rsp_valid", rsp_valid, exp_rsp);
            if (t == due) begin
                check("rnd_rsp_val", rsp_val, ev);
                check("rnd_rsp_dz", rsp_dz, edz);
                check("rnd_rsp_to", rsp_to, 1'b0);
            end
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    if ($urandom_range(1, 0) == 0) req_valid[i] = 1'b0;
                    else new_op(i);
                end else if (req_valid[i]) begin
                    if ($urandom_range(15, 0) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    new_op(i);
                end
            end
        end
        req_valid = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int acc_wait, start_lat, rsp_lat, acc, ng, nr;
        logic [NREQ-1:0] rv;
        logic [W-1:0] val;
        logic dz, to;
        logic [NREQ-1:0] gr[4];
        int gt[4];
        logic [NREQ-1:0] rr[4];
        logic [W-1:0] rvv[4];
        bit saw_r1_ready, saw_rsp1, saw_spur_rsp;
        int rsp0_cnt, nonzero_after_rst;

        vecs[0] = '{0, 20'd100,    20'd7,     1'b0, 20'd14,   1'b0, 1'b0, 13};
        vecs[1] = '{1, 20'd5,      20'd0,     1'b0, 20'hFFFFF, 1'b1, 1'b0, 3};
        vecs[2] = '{0, 20'd60,     20'd3,     1'b0, 20'd20,   1'b0, 1'b0, 13};
        vecs[3] = '{1, 20'hFFFFF,  20'd1,     1'b0, 20'hFFFFF, 1'b0, 1'b0, 13};
        vecs[4] = '{1, 20'h12345,  20'h400,   1'b0, 20'd72,   1'b0, 1'b0, 13};
        vecs[5] = '{0, 20'd7,      20'd9,     1'b0, 20'd0,    1'b0, 1'b0, 13};
        vecs[6] = '{0, 20'd0,      20'd0,     1'b0, 20'hFFFFF, 1'b1, 1'b0, 3};
        vecs[7] = '{1, 20'd1000,   20'd10,    1'b1, 20'hFFFFF, 1'b0, 1'b1, TIMEOUT + 3};
        vecs[8] = '{0, 20'd1000,   20'd10,    1'b0, 20'd100,  1'b0, 1'b0, 13};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        spur_done = 1'b0; hang = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", req_ready, '0);
        check("reset_rsp_valid", rsp_valid, '0);
        check("reset_div_start", div_start, 1'b0);
        check("reset_rsp_val", rsp_val, '0);
        check("reset_div_a", div_a, '0);
        check("reset_div_b", div_b, '0);
        check("reset_rsp_flags", {rsp_dz, rsp_to}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table of single operations, back to back
        for (int i = 0; i < 9; i++) begin
            hang = vecs[i].hang;
            run_op(vecs[i].r, vecs[i].a, vecs[i].b, acc_wait, start_lat, rsp_lat, rv, val, dz, to);
            hang = 1'b0;
            check($sformatf("vec%0d_accept", i), acc_wait, 0);
            check($sformatf("vec%0d_start_lat", i), start_lat, 1);
            check($sformatf("vec%0d_rsp_lat", i), rsp_lat, vecs[i].elat);
            check($sformatf("vec%0d_owner", i), rv, NREQ'(1) << vecs[i].r);
            check($sformatf("vec%0d_val", i), val, vecs[i].ev);
            check($sformatf("vec%0d_dz", i), dz, vecs[i].edz);
            check($sformatf("vec%0d_to", i), to, vecs[i].eto);
        end

        // Contention: both requesters valid from reset
        req_a = {20'hFFFFF, 20'd60};
        req_b = {20'd1, 20'd3};
        req_valid = 2'b11;
        do_reset();
        ng = 0; nr = 0;
        for (int t = 0; t < 100 && nr < 4; t++) begin
            @(negedge clk);
            if (req_ready != '0 && ng < 4) begin gr[ng] = req_ready; gt[ng] = t; ng++; end
            if (rsp_valid != '0 && nr < 4) begin rr[nr] = rsp_valid; rvv[nr] = rsp_val; nr++; end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        check("cont_grants", ng, 4);
        check("cont_rsps", nr, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) begin
                check($sformatf("cont_grant%0d", k), gr[k], (k % 2) ? 2'b10 : 2'b01);
                check($sformatf("cont_gap%0d", k), gt[k] - gt[0], 14 * k);
            end
            if (k < nr) begin
                check($sformatf("cont_rsp_owner%0d", k), rr[k], (k % 2) ? 2'b10 : 2'b01);
                check($sformatf("cont_rsp_val%0d", k), rvv[k], (k % 2) ? 20'hFFFFF : 20'd20);
            end
        end

        // Reset in WAIT (T+6)
        req_a[0 +: W] = 20'd100;
        req_b[0 +: W] = 20'd7;
        req_valid[0] = 1'b1;
        acc = -1;
        for (int t = 0; t < 20 && acc < 0; t++) begin
            @(negedge clk);
            if (req_ready[0]) acc = t;
            @(posedge clk);
            #1;
        end
        req_valid[0] = 1'b0;
        check("rst_mid_accept", acc >= 0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_req_ready", req_ready, '0);
        check("rst_mid_rsp_valid", rsp_valid, '0);
        check("rst_mid_div_start", div_start, 1'b0);
        check("rst_mid_rsp_val", rsp_val, '0);
        check("rst_mid_div_a", div_a, '0);
        check("rst_mid_div_b", div_b, '0);
        check("rst_mid_flags", {rsp_dz, rsp_to}, 2'b00);
        nonzero_after_rst = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp_valid != '0) nonzero_after_rst++;
        end
        check("rst_mid_no_rsp", nonzero_after_rst, 0);
        @(posedge clk);
        #1;
        run_op(0, 20'd100, 20'd7, acc_wait, start_lat, rsp_lat, rv, val, dz, to);
        check("rst_fresh_accept", acc_wait, 0);
        check("rst_fresh_lat", rsp_lat, 13);
        check("rst_fresh_val", val, 20'd14);
        check("rst_fresh_owner", rv, 2'b01);

        // Withdrawal before grant, then spurious done in IDLE
        do_reset();
        req_a[0 +: W] = 20'd100;
        req_b[0 +: W] = 20'd7;
        req_valid[0] = 1'b1;
        acc = -1;
        for (int t = 0; t < 20 && acc < 0; t++) begin
            @(negedge clk);
            if (req_ready[0]) acc = t;
            @(posedge clk);
            #1;
        end
        req_valid[0] = 1'b0;
        check("wd_accept0", acc >= 0, 1'b1);
        saw_r1_ready = 1'b0; saw_rsp1 = 1'b0; saw_spur_rsp = 1'b0; rsp0_cnt = 0;
        for (int t = 1; t <= 40; t++) begin
            if (t == 1) begin
                req_a[W +: W] = 20'd50;
                req_b[W +: W] = 20'd5;
                req_valid[1] = 1'b1;
            end
            if (t == 10) req_valid[1] = 1'b0;
            spur_done = (t == 20);
            @(negedge clk);
            if (req_ready[1]) saw_r1_ready = 1'b1;
            if (rsp_valid[1]) saw_rsp1 = 1'b1;
            if (rsp_valid[0]) rsp0_cnt++;
            if (t > 20 && rsp_valid != '0) saw_spur_rsp = 1'b1;
            @(posedge clk);
            #1;
        end
        spur_done = 1'b0;
        check("wd_r1_never_ready", saw_r1_ready, 1'b0);
        check("wd_r1_never_rsp", saw_rsp1, 1'b0);
        check("wd_r0_one_rsp", rsp0_cnt, 1);
        check("spur_done_no_rsp", saw_spur_rsp, 1'b0);

        // Randomized traffic against the transaction-level reference
        do_reset();
        random_phase(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sfp_div_arbiter.md
# sfp_div_arbiter

Round-robin arbiter and sequencer that shares one `sfp_custom_div` radix-4 divider (10-iteration, 20-bit) among `NREQ` requesters, e.g. the two cores' SFP normalization paths in the dual-core design.
- It accepts one division request at a time through a valid/ready handshake.
- It drives the divider's `start`/`a`/`b` and waits for `done`.
- It returns the quotient, plus divide-by-zero and timeout flags, to the requester that owns the operation.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `W`, 20: operand/quotient width. Must equal the divider width.
- `TIMEOUT`, 31: maximum cycles spent in WAIT before the operation is aborted. Counter is 8 bits.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  one-hot accept strobe.
- `req_a`  in  NREQ*W  dividend; requester i uses bits [i*W +: W].
- `req_b`  in  NREQ*W  divisor, same packing as `req_a`.
- `rsp_valid`  out  NREQ  one-cycle one-hot response strobe to the owner.
- `rsp_val`  out  W  quotient; valid while any `rsp_valid` bit is high.
- `rsp_dz`  out  1  divide-by-zero flag, qualified by `rsp_valid`.
- `rsp_to`  out  1  timeout flag, qualified by `rsp_valid`.
- `div_start`  out  1  divider start pulse.
- `div_a`, `div_b`  out  W  divider operands, registered.
- `div_done`  in  1  divider done pulse.
- `div_valid`  in  1  divider result valid.
- `div_val`  in  W  divider quotient.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` bit is set, grant g = the first set bit searching upward (modulo NREQ) from `last_grant+1`.
  - `req_ready[g]` = 1 combinationally in this cycle only. This is the handshake.
  - Register `req_a[g]`/`req_b[g]` into `div_a`/`div_b` and g into `owner`, then go to ISSUE.
  - If no request is pending, stay in IDLE.
- **ISSUE**
  - `div_start` = 1 for exactly this cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**
  - On `div_done`:
    - `rsp_val` <= `div_valid` ? `div_val` : {W{1'b1}} (saturate on divide-by-zero).
    - `rsp_dz` <= ~`div_valid`; `rsp_to` <= 0.
    - Go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: `rsp_val` <= {W{1'b1}}, `rsp_to` <= 1, `rsp_dz` <= 0, go to RESP.
- **RESP**
  - `rsp_valid[owner]` = 1 for one cycle.
  - `last_grant` <= owner.
  - Go to IDLE.
- Requester obligations:
  - Hold `req_a`/`req_b` stable while `req_valid` is high and `req_ready` is low.
  - Drop or renew `req_valid` after the accept cycle. Withdrawing before accept is legal.
- Requesters have no way to abort an operation once it is accepted.
- `div_done` is ignored in every state except WAIT.
- At most one operation is outstanding. `req_ready` is 0 outside IDLE.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = NREQ-1, so requester 0 wins first.
  - `req_ready`, `rsp_valid`, `div_start` = 0.
  - `rsp_val`, `div_a`, `div_b` = 0.
  - `rsp_dz`, `rsp_to` = 0, `owner` = 0, timeout counter = 0.
- Normal case, accept in cycle T:
  - `div_start` in T+1.
  - Divider busy T+2..T+11.
  - `div_done` in T+12.
  - `rsp_valid` in T+13.
  - Earliest next accept in T+14, giving a throughput of 1 operation per 14 cycles.
- Divide-by-zero: `div_done` in T+2, `rsp_valid` in T+3, next accept in T+4.
- Timeout: `rsp_valid` at T+2+TIMEOUT+1 if `div_done` never arrives.
- Arbitration is fair. With all NREQ requesters continuously valid, each is served exactly once in every NREQ consecutive grants.
- Reset mid-operation (any state): return to IDLE with all outputs at reset values. The in-flight operation is dropped and no response is issued. The shared `rst` also resets the divider.

## Test plan
- **Single quotient.** Requester 0 requests a=100, b=7 → `req_ready[0]` in T, `div_start` in T+1, `rsp_valid`=2'b01 in T+13 with `rsp_val`=14, `rsp_dz`=0, `rsp_to`=0.
- **Divide by zero.** Requester 1 requests a=5, b=0 → `rsp_valid`=2'b10 in T+3 with `rsp_val`=0xFFFFF, `rsp_dz`=1.
- **Contention.** Both requesters hold `req_valid` from reset, requester 0 with 60/3 and requester 1 with 0xFFFFF/1:
  - requester 0 is granted first → 20;
  - requester 1 is granted 14 cycles later → 0xFFFFF;
  - continued load alternates grants 0,1,0,1.
- **Timeout.** Divider stub never asserts done → `rsp_to`=1, `rsp_val`=0xFFFFF exactly TIMEOUT+1 cycles after WAIT entry, then the arbiter accepts the next request.
- **Reset mid-operation.** Assert `rst` for 1 cycle in WAIT (T+6) → no `rsp_valid`, all outputs 0. A fresh 100/7 request then completes in 13 cycles.
- **Early withdrawal and spurious done.** Requester 1 withdraws `req_valid` before its grant → it is never granted. A spurious `div_done` in IDLE → no response.
